// File: rtl/gpio_param_subunit.sv
// rtl/gpio_param_subunit.sv - Parametrised APB-side GPIO subunit with per-pin interrupt modes
// Optional per-pin input debounce filter is built when GPIO_DEBOUNCE_EN is defined.
module gpio_param_subunit #(
  parameter int GPIO_W = 16,
  parameter int ADDR_W = 6,
  parameter int DB_W   = 8
) (
  input  logic              pclk,
  input  logic              n_reset,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [GPIO_W-1:0] wdata,
  input  logic [GPIO_W-1:0] pin_in,
  input  logic [GPIO_W-1:0] tri_state_enable,
  output logic [GPIO_W-1:0] rdata,
  output logic [GPIO_W-1:0] pin_out,
  output logic [GPIO_W-1:0] pin_oe_n,
  output logic [GPIO_W-1:0] interrupt,
  output logic              irq
);

  localparam logic [ADDR_W-1:0] A_DIR  = ADDR_W'(8'h04);
  localparam logic [ADDR_W-1:0] A_OE   = ADDR_W'(8'h08);
  localparam logic [ADDR_W-1:0] A_OUT  = ADDR_W'(8'h0C);
  localparam logic [ADDR_W-1:0] A_IN   = ADDR_W'(8'h10);
  localparam logic [ADDR_W-1:0] A_MASK = ADDR_W'(8'h14);
  localparam logic [ADDR_W-1:0] A_TYPE = ADDR_W'(8'h18);
  localparam logic [ADDR_W-1:0] A_POL  = ADDR_W'(8'h1C);
  localparam logic [ADDR_W-1:0] A_BOTH = ADDR_W'(8'h20);
  localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(8'h24);
  localparam logic [ADDR_W-1:0] A_DB   = ADDR_W'(8'h28);

  logic [GPIO_W-1:0] dir, oe, out_val, int_mask, int_type, int_pol, int_both, int_status;
  logic [GPIO_W-1:0] sync1, sync2, in_val, in_prev;
  logic [GPIO_W-1:0] w1c_mask, rise, fall, edge_ev, lvl_ev, pin_event;
  logic [GPIO_W-1:0] rd_mux;
  logic [DB_W-1:0]   db_cfg;

  assign w1c_mask = (write && addr == A_STAT) ? wdata : '0;

  assign rise      = in_val & ~in_prev;
  assign fall      = ~in_val & in_prev;
  assign edge_ev   = (int_both & (rise | fall)) | (~int_both & ((int_pol & rise) | (~int_pol & fall)));
  assign lvl_ev    = (int_pol & in_val) | (~int_pol & ~in_val);
  assign pin_event = dir & ((int_type & lvl_ev) | (~int_type & edge_ev));

  always_ff @(posedge pclk or negedge n_reset) begin
    if (!n_reset) begin
      dir        <= '0;
      oe         <= '0;
      out_val    <= '0;
      int_mask   <= '0;
      int_type   <= '0;
      int_pol    <= '0;
      int_both   <= '0;
      int_status <= '0;
    end else begin
      if (write) begin
        case (addr)
          A_DIR:   dir      <= wdata;
          A_OE:    oe       <= wdata;
          A_OUT:   out_val  <= wdata;
          A_MASK:  int_mask <= wdata;
          A_TYPE:  int_type <= wdata;
          A_POL:   int_pol  <= wdata;
          A_BOTH:  int_both <= wdata;
          default: ;
        endcase
      end
      // A new event outranks a W1C landing in the same cycle.
      int_status <= (int_status & ~w1c_mask) | pin_event;
    end
  end

  always_ff @(posedge pclk or negedge n_reset) begin
    if (!n_reset) begin
      sync1   <= '0;
      sync2   <= '0;
      in_prev <= '0;
    end else begin
      sync1   <= pin_in;
      sync2   <= sync1;
      in_prev <= in_val;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  logic [DB_W-1:0] db_cnt [GPIO_W];

  always_ff @(posedge pclk or negedge n_reset) begin
    if (!n_reset) begin
      db_cfg <= '0;
    end else if (write && addr == A_DB) begin
      db_cfg <= DB_W'(wdata);
    end
  end

  // db_cnt counts consecutive cycles where sync2 disagrees with in_val.
  always_ff @(posedge pclk or negedge n_reset) begin
    if (!n_reset) begin
      in_val <= '0;
      for (int i = 0; i < GPIO_W; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < GPIO_W; i++) begin
        if (db_cfg == '0) begin
          in_val[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else if (sync2[i] == in_val[i]) begin
          db_cnt[i] <= '0;
        end else if (({1'b0, db_cnt[i]} + (DB_W+1)'(1)) >= {1'b0, db_cfg}) begin
          in_val[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else if (db_cnt[i] != '1) begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end
`else
  assign db_cfg = '0;

  always_ff @(posedge pclk or negedge n_reset) begin
    if (!n_reset) begin
      in_val <= '0;
    end else begin
      in_val <= sync2;
    end
  end
`endif

  always_comb begin
    rd_mux = '0;
    case (addr)
      A_DIR:   rd_mux = dir;
      A_OE:    rd_mux = oe;
      A_OUT:   rd_mux = out_val;
      A_IN:    rd_mux = in_val;
      A_MASK:  rd_mux = int_mask;
      A_TYPE:  rd_mux = int_type;
      A_POL:   rd_mux = int_pol;
      A_BOTH:  rd_mux = int_both;
      A_STAT:  rd_mux = int_status;
      A_DB:    rd_mux = GPIO_W'(db_cfg);
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge pclk or negedge n_reset) begin
    if (!n_reset) begin
      rdata <= '0;
    end else begin
      rdata <= read ? rd_mux : '0;
    end
  end

  assign pin_out   = out_val;
  assign pin_oe_n  = ~(oe & ~dir) | tri_state_enable;
  assign interrupt = int_status & int_mask;
  assign irq       = |interrupt;

endmodule

// File: tb/tb_gpio_param_subunit.sv
// tb/tb_gpio_param_subunit.sv - Directed self-checking bench for gpio_param_subunit
module tb_gpio_param_subunit;

  logic        pclk = 1'b0;
  logic        n_reset = 1'b0;
  logic        read, write;
  logic [5:0]  addr;
  logic [15:0] wdata, pin_in, tri_state_enable;
  logic [15:0] rdata, pin_out, pin_oe_n, interrupt;
  logic        irq;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] A_DIR = 6'h04, A_OE = 6'h08, A_OUT = 6'h0C, A_IN = 6'h10;
  localparam logic [5:0] A_MASK = 6'h14, A_TYPE = 6'h18, A_POL = 6'h1C, A_BOTH = 6'h20;
  localparam logic [5:0] A_STAT = 6'h24, A_DB = 6'h28;

  gpio_param_subunit #(.GPIO_W(16), .ADDR_W(6), .DB_W(8)) dut (
    .pclk(pclk), .n_reset(n_reset), .read(read), .write(write), .addr(addr),
    .wdata(wdata), .pin_in(pin_in), .tri_state_enable(tri_state_enable),
    .rdata(rdata), .pin_out(pin_out), .pin_oe_n(pin_oe_n),
    .interrupt(interrupt), .irq(irq)
  );

  always #5 pclk = ~pclk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [15:0] d);
    write = 1'b1; addr = a; wdata = d;
    tick(1);
    write = 1'b0; wdata = '0;
  endtask

  task automatic rd(input logic [5:0] a, output logic [15:0] d);
    read = 1'b1; addr = a;
    tick(1);
    read = 1'b0;
    d = rdata;
  endtask

  task automatic do_reset();
    n_reset = 1'b0; read = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    pin_in = '0; tri_state_enable = '0;
    repeat (3) @(posedge pclk);
    #1 n_reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [5:0]  addrs [10];
    logic [15:0] d;
    addrs = '{A_DIR, A_OE, A_OUT, A_IN, A_MASK, A_TYPE, A_POL, A_BOTH, A_STAT, A_DB};
    do_reset();
    checks++; if (pin_oe_n !== 16'hFFFF) begin errors++; $display("FAIL reset_oe_n got %h exp FFFF", pin_oe_n); end
    checks++; if (irq !== 1'b0 || interrupt !== 16'h0) begin errors++; $display("FAIL reset_irq got %b/%h exp 0/0000", irq, interrupt); end
    checks++; if (pin_out !== 16'h0) begin errors++; $display("FAIL reset_pin_out got %h exp 0000", pin_out); end
    for (int i = 0; i < 10; i++) begin
      rd(addrs[i], d);
      checks++; if (d !== 16'h0) begin errors++; $display("FAIL reset_read addr %h got %h exp 0000", addrs[i], d); end
    end
  endtask

  task automatic test_output_path();
    logic [15:0] d;
    do_reset();
    wr(A_DIR, 16'h0000);
    wr(A_OE, 16'h00FF);
    wr(A_OUT, 16'h00A5);
    checks++; if (pin_out !== 16'h00A5) begin errors++; $display("FAIL out_pin_out got %h exp 00A5", pin_out); end
    checks++; if (pin_oe_n !== 16'hFF00) begin errors++; $display("FAIL out_oe_n got %h exp FF00", pin_oe_n); end
    tri_state_enable = 16'h0001;
    #1;
    checks++; if (pin_oe_n !== 16'hFF01) begin errors++; $display("FAIL out_tse got %h exp FF01", pin_oe_n); end
    tri_state_enable = 16'h0000;
    wr(A_DIR, 16'h000F);
    checks++; if (pin_oe_n !== 16'hFF0F) begin errors++; $display("FAIL out_dir_oe got %h exp FF0F", pin_oe_n); end
    rd(A_OE, d);
    checks++; if (d !== 16'h00FF) begin errors++; $display("FAIL out_oe_read got %h exp 00FF", d); end
    tick(1);
    checks++; if (rdata !== 16'h0) begin errors++; $display("FAIL rdata_idle got %h exp 0000", rdata); end
  endtask

  task automatic test_edge_rise();
    logic [15:0] d;
    do_reset();
    wr(A_MASK, 16'h0001);
    wr(A_POL, 16'h0001);
    wr(A_DIR, 16'h0001);
    pin_in = 16'h0001;
    tick(3);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rise_early got %b exp 0", irq); end
    tick(1);
    checks++; if (irq !== 1'b1 || interrupt !== 16'h0001) begin errors++; $display("FAIL rise_irq got %b/%h exp 1/0001", irq, interrupt); end
    rd(A_IN, d);
    checks++; if (d !== 16'h0001) begin errors++; $display("FAIL rise_in_val got %h exp 0001", d); end
    wr(A_DIR, 16'h0000);
    rd(A_STAT, d);
    checks++; if (d !== 16'h0001) begin errors++; $display("FAIL rise_dir_keep got %h exp 0001", d); end
    wr(A_STAT, 16'h0001);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rise_w1c_irq got %b exp 0", irq); end
    rd(A_STAT, d);
    checks++; if (d !== 16'h0) begin errors++; $display("FAIL rise_w1c_stat got %h exp 0000", d); end
  endtask

  task automatic test_level_low();
    logic [15:0] d;
    do_reset();
    wr(A_TYPE, 16'h0008);
    wr(A_MASK, 16'h0008);
    wr(A_DIR, 16'h0008);
    tick(1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL lvl_set got %b exp 1", irq); end
    wr(A_STAT, 16'h0008);
    rd(A_STAT, d);
    checks++; if (d !== 16'h0008) begin errors++; $display("FAIL lvl_w1c_blocked got %h exp 0008", d); end
    pin_in = 16'h0008;
    tick(4);
    wr(A_STAT, 16'h0008);
    rd(A_STAT, d);
    checks++; if (d !== 16'h0) begin errors++; $display("FAIL lvl_w1c_clear got %h exp 0000", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL lvl_irq_clear got %b exp 0", irq); end
  endtask

  task automatic test_both_edges();
    logic [15:0] d;
    do_reset();
    wr(A_BOTH, 16'h0020);
    wr(A_DIR, 16'h0020);
    pin_in = 16'h0020;
    tick(4);
    rd(A_STAT, d);
    checks++; if (d !== 16'h0020) begin errors++; $display("FAIL both_rise got %h exp 0020", d); end
    checks++; if (irq !== 1'b0 || interrupt !== 16'h0) begin errors++; $display("FAIL both_masked got %b/%h exp 0/0000", irq, interrupt); end
    wr(A_STAT, 16'h0020);
    rd(A_STAT, d);
    checks++; if (d !== 16'h0) begin errors++; $display("FAIL both_clear got %h exp 0000", d); end
    pin_in = 16'h0000;
    tick(4);
    rd(A_STAT, d);
    checks++; if (d !== 16'h0020) begin errors++; $display("FAIL both_fall got %h exp 0020", d); end
    wr(A_MASK, 16'h0020);
    checks++; if (irq !== 1'b1 || interrupt !== 16'h0020) begin errors++; $display("FAIL both_unmask got %b/%h exp 1/0020", irq, interrupt); end
  endtask

  task automatic test_dir_gate_and_map();
    logic [15:0] d;
    do_reset();
    wr(A_POL, 16'h0002);
    pin_in = 16'h0002;
    tick(4);
    rd(A_STAT, d);
    checks++; if (d !== 16'h0) begin errors++; $display("FAIL gate_no_event got %h exp 0000", d); end
    wr(A_IN, 16'hFFFF);
    rd(A_IN, d);
    checks++; if (d !== 16'h0002) begin errors++; $display("FAIL ro_write got %h exp 0002", d); end
    wr(6'h3C, 16'h1234);
    rd(6'h3C, d);
    checks++; if (d !== 16'h0) begin errors++; $display("FAIL unmapped_read got %h exp 0000", d); end
    rd(A_DIR, d);
    checks++; if (d !== 16'h0) begin errors++; $display("FAIL unmapped_write got %h exp 0000", d); end
  endtask

  task automatic test_async_reset();
    do_reset();
    wr(A_OE, 16'hFFFF);
    wr(A_TYPE, 16'h0001);
    wr(A_MASK, 16'h0001);
    wr(A_DIR, 16'h0000);
    wr(A_POL, 16'h0000);
    wr(A_DIR, 16'h0001);
    tick(1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL arst_pre got %b exp 1", irq); end
    #2 n_reset = 1'b0;
    #1;
    checks++; if (irq !== 1'b0 || pin_oe_n !== 16'hFFFF) begin errors++; $display("FAIL arst_now got %b/%h exp 0/FFFF", irq, pin_oe_n); end
    do_reset();
  endtask

  task automatic test_debounce();
    logic [15:0] d;
    do_reset();
`ifdef GPIO_DEBOUNCE_EN
    wr(A_DB, 16'h0004);
    rd(A_DB, d);
    checks++; if (d !== 16'h0004) begin errors++; $display("FAIL db_cfg_read got %h exp 0004", d); end
    wr(A_POL, 16'h0001);
    wr(A_DIR, 16'h0001);
    pin_in = 16'h0001;
    tick(2);
    pin_in = 16'h0000;
    tick(10);
    rd(A_IN, d);
    checks++; if (d !== 16'h0) begin errors++; $display("FAIL db_glitch_in got %h exp 0000", d); end
    rd(A_STAT, d);
    checks++; if (d !== 16'h0) begin errors++; $display("FAIL db_glitch_stat got %h exp 0000", d); end
    pin_in = 16'h0001;
    tick(5);
    rd(A_IN, d);
    checks++; if (d !== 16'h0) begin errors++; $display("FAIL db_hold_in got %h exp 0000", d); end
    tick(4);
    rd(A_IN, d);
    checks++; if (d !== 16'h0001) begin errors++; $display("FAIL db_pulse_in got %h exp 0001", d); end
    rd(A_STAT, d);
    checks++; if (d !== 16'h0001) begin errors++; $display("FAIL db_pulse_stat got %h exp 0001", d); end
`else
    wr(A_DB, 16'h0004);
    rd(A_DB, d);
    checks++; if (d !== 16'h0) begin errors++; $display("FAIL db_absent got %h exp 0000", d); end
    pin_in = 16'h0001;
    tick(3);
    rd(A_IN, d);
    checks++; if (d !== 16'h0001) begin errors++; $display("FAIL db_absent_path got %h exp 0001", d); end
`endif
  endtask

  initial begin
    test_reset();
    test_output_path();
    test_edge_rise();
    test_level_low();
    test_both_edges();
    test_dir_gate_and_map();
    test_async_reset();
    test_debounce();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
